// File: rtl/mult_x.sv
// Two-stage unsigned multiply-add: out = (A*B + C) mod 2^WIRE, with a valid qualifier and an overflow flag.
// The product array is a shift-and-add of A, one row per multiplier bit. C is the seed of the row chain.
module mult_x #(
  parameter int unsigned WIRE = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [WIRE-1:0] A,
  input  logic [WIRE-1:0] B,
  input  logic [WIRE-1:0] C,
  input  logic            in_valid,
  output logic [WIRE-1:0] out,
  output logic            out_valid,
  output logic            ovf
);

  localparam int unsigned SW = 2 * WIRE + 1;

  logic [WIRE-1:0] a_q, b_q, c_q;
  logic            vld1_q;
  logic [WIRE-1:0] out_q, out_d;
  logic            ovf_q, ovf_d;
  logic            vld2_q;

  logic [SW-1:0]   a_ext;
  logic [SW-1:0]   sum;

  // Stage 1 captures every cycle; in_valid only travels alongside the data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q    <= '0;
      b_q    <= '0;
      c_q    <= '0;
      vld1_q <= 1'b0;
    end else begin
      a_q    <= A;
      b_q    <= B;
      c_q    <= C;
      vld1_q <= in_valid;
    end
  end

  assign a_ext = {{(SW - WIRE){1'b0}}, a_q};

  always_comb begin
    sum = {{(SW - WIRE){1'b0}}, c_q};
    for (int i = 0; i < WIRE; i++) begin
      if (b_q[i]) sum = sum + (a_ext << i);
    end
  end

  assign out_d = sum[WIRE-1:0];
  assign ovf_d = |sum[SW-1:WIRE];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q  <= '0;
      ovf_q  <= 1'b0;
      vld2_q <= 1'b0;
    end else begin
      out_q  <= out_d;
      ovf_q  <= ovf_d;
      vld2_q <= vld1_q;
    end
  end

  assign out       = out_q;
  assign ovf       = ovf_q;
  assign out_valid = vld2_q;

endmodule

// File: tb/tb_mult_x.sv
// Directed + random bench for mult_x: expectations queued at drive time, popped when the result is due.
module tb_mult_x;

  localparam int W = 8;

  typedef struct packed {
    logic [W-1:0] o;
    logic         f;
    logic         v;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] a, b, c;
  logic         in_valid;
  logic [W-1:0] out;
  logic         out_valid;
  logic         ovf;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  mult_x #(.WIRE(W)) dut (
    .clk(clk), .rst(rst), .A(a), .B(b), .C(c), .in_valid(in_valid),
    .out(out), .out_valid(out_valid), .ovf(ovf)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one operation, let one edge pass, and compare the result that is due after that edge.
  task automatic step(input logic [W-1:0] ai, input logic [W-1:0] bi,
                      input logic [W-1:0] ci, input logic vi, input string tag);
    longint unsigned full;
    exp_t e;
    @(negedge clk);
    a = ai; b = bi; c = ci; in_valid = vi;
    full = longint'(ai) * longint'(bi) + longint'(ci);
    e.o = full[W-1:0];
    e.f = (full >> W) != 0;
    e.v = vi;
    q.push_back(e);
    @(posedge clk);
    #1;
    if (q.size() == 2) begin
      e = q.pop_front();
      chk({tag, ".out"}, 64'(out), 64'(e.o));
      chk({tag, ".ovf"}, 64'(ovf), 64'(e.f));
      chk({tag, ".vld"}, 64'(out_valid), 64'(e.v));
    end
  endtask

  initial begin
    rst = 1'b0; a = '0; b = '0; c = '0; in_valid = 1'b0;
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("rst_async.out", 64'(out), 64'd0);
    chk("rst_async.ovf", 64'(ovf), 64'd0);
    chk("rst_async.vld", 64'(out_valid), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    step(0, 0, 0, 1, "zero");
    step(3, 5, 0, 1, "3x5");
    step(8, 12, 0, 1, "8x12");
    step(3, 10, 0, 1, "3x10");
    step(7, 9, 4, 1, "madd");
    step(200, 2, 0, 1, "wrap");
    step(255, 255, 255, 1, "max");
    step(0, 77, 9, 1, "by0");
    step(123, 1, 100, 1, "by1");
    step(0, 0, 0, 0, "gap0");
    step(0, 0, 0, 1, "gap1");
    step(0, 0, 0, 0, "gap2");
    step(0, 0, 0, 1, "gap3");
    step(0, 0, 0, 0, "gap4");

    for (int i = 0; i < 24; i++)
      step(W'($urandom), W'($urandom), W'($urandom), 1'($urandom), "rand");

    // A valid op sits in stage 1 when reset hits; it must never surface.
    step(9, 9, 9, 1, "pre_rst");
    #2;
    rst = 1'b1;
    #1;
    chk("rst_mid.out", 64'(out), 64'd0);
    chk("rst_mid.vld", 64'(out_valid), 64'd0);
    q.delete();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_mid.post_vld", 64'(out_valid), 64'd0);
    step(0, 0, 0, 0, "post0");
    step(15, 17, 1, 1, "post1");
    step(0, 0, 0, 0, "drain0");
    step(0, 0, 0, 0, "drain1");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
